// File: rtl/mmr_regfile.sv
// AXI4-Lite register file: control/status, per-queue descriptor
// bases, and per-queue interrupt enable/status with registered irq.
module mmr_regfile #(
  parameter int unsigned NQUEUES       = 2,
  parameter int unsigned NEVENTS       = 16,
  parameter logic [31:0] CONTROL_RESET = 32'h0
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [9:0]                  s_axil_awaddr,
  input  logic                        s_axil_awvalid,
  output logic                        s_axil_awready,
  input  logic [31:0]                 s_axil_wdata,
  input  logic [3:0]                  s_axil_wstrb,
  input  logic                        s_axil_wvalid,
  output logic                        s_axil_wready,
  output logic [1:0]                  s_axil_bresp,
  output logic                        s_axil_bvalid,
  input  logic                        s_axil_bready,
  input  logic [9:0]                  s_axil_araddr,
  input  logic                        s_axil_arvalid,
  output logic                        s_axil_arready,
  output logic [31:0]                 s_axil_rdata,
  output logic [1:0]                  s_axil_rresp,
  output logic                        s_axil_rvalid,
  input  logic                        s_axil_rready,
  output logic [31:0]                 control,
  input  logic [31:0]                 status,
  input  logic [32*NQUEUES-1:0]       rx_desc_base,
  input  logic [32*NQUEUES-1:0]       tx_desc_base,
  input  logic [NEVENTS*NQUEUES-1:0]  events,
  output logic [NQUEUES-1:0]          irq
);

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  typedef enum logic [3:0] {
    SEL_NONE, SEL_CTRL, SEL_STAT, SEL_RX, SEL_TX,
    SEL_IER, SEL_IDR, SEL_IMR, SEL_ISR
  } sel_e;

  localparam logic [3:0] NQ = 4'(NQUEUES);

  // Word index: bits [7:3] pick the block, [2:0] the queue.
  function automatic sel_e decode(input logic [7:0] w);
    logic qok;
    sel_e s;
    qok = ({1'b0, w[2:0]} < NQ);
    s   = SEL_NONE;
    unique case (1'b1)
      (w == 8'd1):                s = SEL_CTRL;
      (w == 8'd2):                s = SEL_STAT;
      (w[7:3] == 5'd2  && qok):   s = SEL_RX;
      (w[7:3] == 5'd4  && qok):   s = SEL_TX;
      (w[7:3] == 5'd8  && qok):   s = SEL_IER;
      (w[7:3] == 5'd9  && qok):   s = SEL_IDR;
      (w[7:3] == 5'd10 && qok):   s = SEL_IMR;
      (w[7:3] == 5'd11 && qok):   s = SEL_ISR;
      default:                    s = SEL_NONE;
    endcase
    return s;
  endfunction

  w_state_e w_state_q;
  r_state_e r_state_q;

  logic [31:0]        control_q, control_d;
  logic [31:0]        rdata_q;
  logic [1:0]         bresp_q, rresp_q;
  logic [NEVENTS-1:0] imr_q [NQUEUES];
  logic [NEVENTS-1:0] isr_q [NQUEUES];
  logic [NEVENTS-1:0] imr_d [NQUEUES];
  logic [NEVENTS-1:0] isr_d [NQUEUES];
  logic [NQUEUES-1:0] irq_q;

  sel_e        wsel, rsel;
  logic [2:0]  wq, rq;
  logic        wr_acc, wr_ok;
  logic        rd_err;
  logic [31:0] rd_val;
  logic [31:0] q_rx, q_tx, q_imr, q_isr;

  wire unused_ok = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  assign wsel = decode(s_axil_awaddr[9:2]);
  assign rsel = decode(s_axil_araddr[9:2]);
  assign wq   = s_axil_awaddr[4:2];
  assign rq   = s_axil_araddr[4:2];

  assign wr_acc = (w_state_q == W_IDLE) &&
                  s_axil_awvalid && s_axil_wvalid;
  assign wr_ok  = (wsel == SEL_CTRL) || (wsel == SEL_IER) ||
                  (wsel == SEL_IDR)  || (wsel == SEL_ISR);

  assign s_axil_awready = resetn && wr_acc;
  assign s_axil_wready  = resetn && wr_acc;
  assign s_axil_bvalid  = (w_state_q == W_RESP);
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = resetn && (r_state_q == R_IDLE);
  assign s_axil_rvalid  = (r_state_q == R_DATA);
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign control        = control_q;
  assign irq            = irq_q;

  always_comb begin
    q_rx  = '0;
    q_tx  = '0;
    q_imr = '0;
    q_isr = '0;
    for (int i = 0; i < NQUEUES; i++) begin
      if (rq == 3'(i)) begin
        q_rx               = rx_desc_base[32*i +: 32];
        q_tx               = tx_desc_base[32*i +: 32];
        q_imr[NEVENTS-1:0] = imr_q[i];
        q_isr[NEVENTS-1:0] = isr_q[i];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    case (rsel)
      SEL_CTRL: rd_val = control_q;
      SEL_STAT: rd_val = status;
      SEL_RX:   rd_val = q_rx;
      SEL_TX:   rd_val = q_tx;
      SEL_IMR:  rd_val = q_imr;
      SEL_ISR:  rd_val = q_isr;
      default:  rd_err = 1'b1;
    endcase
  end

  always_comb begin
    control_d = control_q;
    if (wr_acc && wsel == SEL_CTRL) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axil_wstrb[b]) begin
          control_d[8*b +: 8] = s_axil_wdata[8*b +: 8];
        end
      end
    end
  end

  // Event set is OR-ed after the W1C so a coincident event wins.
  always_comb begin
    for (int i = 0; i < NQUEUES; i++) begin
      imr_d[i] = imr_q[i];
      isr_d[i] = isr_q[i];
      if (wr_acc && wq == 3'(i)) begin
        if (wsel == SEL_IER)
          imr_d[i] = imr_q[i] | s_axil_wdata[NEVENTS-1:0];
        if (wsel == SEL_IDR)
          imr_d[i] = imr_q[i] & ~s_axil_wdata[NEVENTS-1:0];
        if (wsel == SEL_ISR)
          isr_d[i] = isr_q[i] & ~s_axil_wdata[NEVENTS-1:0];
      end
      isr_d[i] = isr_d[i] | events[NEVENTS*i +: NEVENTS];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      w_state_q <= W_IDLE;
      bresp_q   <= 2'b00;
      control_q <= CONTROL_RESET;
    end else begin
      control_q <= control_d;
      unique case (w_state_q)
        W_IDLE: if (wr_acc) begin
          w_state_q <= W_RESP;
          bresp_q   <= wr_ok ? 2'b00 : 2'b10;
        end
        W_RESP: if (s_axil_bready) w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      unique case (r_state_q)
        R_IDLE: if (s_axil_arvalid) begin
          r_state_q <= R_DATA;
          rdata_q   <= rd_val;
          rresp_q   <= rd_err ? 2'b10 : 2'b00;
        end
        R_DATA: if (s_axil_rready) r_state_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      irq_q <= '0;
      for (int i = 0; i < NQUEUES; i++) begin
        imr_q[i] <= '0;
        isr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NQUEUES; i++) begin
        irq_q[i] <= |(isr_q[i] & imr_q[i]);
        imr_q[i] <= imr_d[i];
        isr_q[i] <= isr_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mmr_regfile.sv
// Directed bench for mmr_regfile with a per-cycle reference model
// of the register map, interrupt state and both AXI4-Lite channels.
module tb_mmr_regfile;

  localparam int NQ  = 2;
  localparam int NEV = 16;
  localparam logic [31:0] CRST = 32'hC0DE_0001;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic [9:0]        awaddr = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [31:0]       wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b1;
  logic [9:0]        araddr = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready = 1'b1;
  logic [31:0]       control;
  logic [31:0]       status = 32'h1234_ABCD;
  logic [32*NQ-1:0]  rx_base = {32'h2000_1000, 32'h2000_0000};
  logic [32*NQ-1:0]  tx_base = {32'h3000_1000, 32'h3000_0000};
  logic [NEV*NQ-1:0] events = '0;
  logic [NQ-1:0]     irq;

  int n_cmp = 0;
  int n_err = 0;

  mmr_regfile #(
    .NQUEUES(NQ), .NEVENTS(NEV), .CONTROL_RESET(CRST)
  ) dut (
    .clock(clock), .resetn(resetn),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid),
    .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid),
    .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid),
    .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp),
    .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .control(control), .status(status),
    .rx_desc_base(rx_base), .tx_desc_base(tx_base),
    .events(events), .irq(irq)
  );

  always #5 clock = ~clock;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // Reference model, expressed as the register map itself.
  logic [31:0]    m_control;
  logic [NEV-1:0] m_imr [NQ];
  logic [NEV-1:0] m_isr [NQ];
  logic [NQ-1:0]  m_irq;
  logic           m_wbusy, m_rbusy;
  logic [1:0]     m_bresp, m_rresp;
  logic [31:0]    m_rdata;

  function automatic void m_reset();
    m_control = CRST;
    m_irq = '0;
    m_wbusy = 1'b0;
    m_rbusy = 1'b0;
    m_bresp = 2'b00;
    m_rresp = 2'b00;
    m_rdata = '0;
    for (int q = 0; q < NQ; q++) begin
      m_imr[q] = '0;
      m_isr[q] = '0;
    end
  endfunction

  function automatic void m_read(input logic [9:0] a,
                                 output logic [31:0] d,
                                 output logic [1:0] r);
    int off;
    int q;
    off = int'({a[9:2], 2'b00});
    q = (off % 32) / 4;
    d = '0;
    r = 2'b10;
    if (off == 4) begin
      d = m_control; r = 2'b00;
    end else if (off == 8) begin
      d = status; r = 2'b00;
    end else if (q < NQ) begin
      if (off >= 'h40 && off < 'h60) begin
        d = rx_base[32*q +: 32]; r = 2'b00;
      end else if (off >= 'h80 && off < 'hA0) begin
        d = tx_base[32*q +: 32]; r = 2'b00;
      end else if (off >= 'h140 && off < 'h160) begin
        d = 32'(m_imr[q]); r = 2'b00;
      end else if (off >= 'h160 && off < 'h180) begin
        d = 32'(m_isr[q]); r = 2'b00;
      end
    end
  endfunction

  function automatic void m_write(input logic [9:0] a,
                                  input logic [31:0] d,
                                  input logic [3:0] s,
                                  output logic [1:0] r);
    int off;
    int q;
    off = int'({a[9:2], 2'b00});
    q = (off % 32) / 4;
    r = 2'b10;
    if (off == 4) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) m_control[8*b +: 8] = d[8*b +: 8];
      r = 2'b00;
    end else if (q < NQ) begin
      if (off >= 'h100 && off < 'h120) begin
        m_imr[q] = m_imr[q] | d[NEV-1:0]; r = 2'b00;
      end else if (off >= 'h120 && off < 'h140) begin
        m_imr[q] = m_imr[q] & ~d[NEV-1:0]; r = 2'b00;
      end else if (off >= 'h160 && off < 'h180) begin
        m_isr[q] = m_isr[q] & ~d[NEV-1:0]; r = 2'b00;
      end
    end
  endfunction

  initial begin
    logic [NQ-1:0] nirq;
    m_reset();
    forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) begin
        m_reset();
      end else begin
        for (int q = 0; q < NQ; q++)
          nirq[q] = |(m_isr[q] & m_imr[q]);
        if (!m_rbusy) begin
          if (arvalid) begin
            m_read(araddr, m_rdata, m_rresp);
            m_rbusy = 1'b1;
          end
        end else if (rready) m_rbusy = 1'b0;
        if (!m_wbusy) begin
          if (awvalid && wvalid) begin
            m_write(awaddr, wdata, wstrb, m_bresp);
            m_wbusy = 1'b1;
          end
        end else if (bready) m_wbusy = 1'b0;
        for (int q = 0; q < NQ; q++)
          m_isr[q] = m_isr[q] | events[NEV*q +: NEV];
        m_irq = nirq;
      end
    end
  end

  always @(negedge clock) begin
    if (resetn) begin
      chk("control", control, m_control);
      chk("irq", 32'(irq), 32'(m_irq));
      chk("bvalid", 32'(bvalid), 32'(m_wbusy));
      chk("rvalid", 32'(rvalid), 32'(m_rbusy));
      if (m_wbusy) chk("bresp", 32'(bresp), 32'(m_bresp));
      if (m_rbusy) begin
        chk("rdata", rdata, m_rdata);
        chk("rresp", 32'(rresp), 32'(m_rresp));
      end
    end
  end

  task automatic axi_wr(input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [1:0] resp);
    logic acc;
    logic got;
    @(negedge clock);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1 acc = awready;
      @(negedge clock);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("aw_accept", 32'(acc), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bvalid) got = 1'b1;
      else @(negedge clock);
    end
    chk("b_wait", 32'(got), 32'd1);
    resp = bresp;
    @(negedge clock);
  endtask

  task automatic axi_rd(input logic [9:0] a, output logic [31:0] d,
                        output logic [1:0] resp);
    logic acc;
    logic got;
    @(negedge clock);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1 acc = arready;
      @(negedge clock);
    end
    arvalid = 1'b0;
    chk("ar_accept", 32'(acc), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (rvalid) got = 1'b1;
      else @(negedge clock);
    end
    chk("r_wait", 32'(got), 32'd1);
    d = rdata;
    resp = rresp;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic        acc;

    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    events = '1;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_control", control, CRST);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_resp", 32'({bresp, rresp}), 32'd0);
    @(negedge clock);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    events = '0;
    #2 resetn = 1'b1;

    axi_wr(10'h004, 32'hA5A5_5A5A, 4'b0101, r);
    chk("ctrl_strb_resp", 32'(r), 32'd0);
    chk("ctrl_strb", control, 32'hC0A5_005A);
    axi_rd(10'h004, d, r);
    chk("rd_ctrl", d, 32'hC0A5_005A);
    axi_rd(10'h00B, d, r);
    chk("rd_status", d, 32'h1234_ABCD);
    axi_rd(10'h044, d, r);
    chk("rd_rx1", d, 32'h2000_1000);
    axi_rd(10'h080, d, r);
    chk("rd_tx0", d, 32'h3000_0000);

    axi_wr(10'h104, 32'h3, 4'hF, r);
    axi_rd(10'h144, d, r);
    chk("rd_imr1", d, 32'h3);
    @(negedge clock);
    events[NEV+0] = 1'b1;
    @(negedge clock);
    events[NEV+0] = 1'b0;
    chk("irq_lat0", 32'(irq), 32'd0);
    @(negedge clock);
    chk("irq_lat1", 32'(irq), 32'b10);
    axi_rd(10'h164, d, r);
    chk("rd_isr1", d, 32'h1);
    axi_wr(10'h164, 32'h1, 4'h0, r);
    chk("irq_clr", 32'(irq), 32'd0);

    @(negedge clock);
    events[NEV+2] = 1'b1;
    axi_wr(10'h164, 32'h4, 4'hF, r);
    axi_rd(10'h164, d, r);
    chk("isr_set_wins", d, 32'h4);
    events[NEV+2] = 1'b0;
    axi_wr(10'h164, 32'h4, 4'hF, r);
    axi_rd(10'h164, d, r);
    chk("isr_w1c", d, 32'h0);

    axi_wr(10'h124, 32'h1, 4'hF, r);
    axi_rd(10'h144, d, r);
    chk("rd_imr_idr", d, 32'h2);
    axi_rd(10'h104, d, r);
    chk("rd_ier_resp", 32'(r), 32'b10);
    chk("rd_ier_data", d, 32'h0);

    axi_rd(10'h148, d, r);
    chk("rd_q2_resp", 32'(r), 32'b10);
    chk("rd_q2_data", d, 32'h0);
    axi_wr(10'h008, 32'hFFFF_FFFF, 4'hF, r);
    chk("wr_status_resp", 32'(r), 32'b10);
    axi_wr(10'h140, 32'hFFFF_FFFF, 4'hF, r);
    chk("wr_imr_resp", 32'(r), 32'b10);
    axi_wr(10'h200, 32'hFFFF_FFFF, 4'hF, r);
    chk("wr_unmapped", 32'(r), 32'b10);
    axi_rd(10'h144, d, r);
    chk("imr_unchanged", d, 32'h2);
    chk("ctrl_unchanged", control, 32'hC0A5_005A);

    @(negedge clock);
    awaddr = 10'h004; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
    araddr = 10'h004;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    #1 acc = awready && arready;
    @(negedge clock);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("rw_accept", 32'(acc), 32'd1);
    chk("rw_old_data", rdata, 32'hC0A5_005A);
    chk("rw_new_ctrl", control, 32'h0BAD_F00D);
    @(negedge clock);

    awaddr = 10'h004; wdata = 32'h1111_1111; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    #1 chk("bp_acc1", 32'(awready), 32'd1);
    @(negedge clock);
    wdata = 32'h2222_2222;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_bvalid", 32'(bvalid), 32'd1);
      chk("bp_awready", 32'(awready), 32'd0);
      @(negedge clock);
    end
    chk("bp_ctrl1", control, 32'h1111_1111);
    bready = 1'b1;
    @(negedge clock);
    #1 chk("bp_acc2", 32'(awready), 32'd1);
    @(negedge clock);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bp_bvalid2", 32'(bvalid), 32'd1);
    chk("bp_ctrl2", control, 32'h2222_2222);
    @(negedge clock);

    axi_wr(10'h100, 32'hFFFF_FFFF, 4'hF, r);
    axi_rd(10'h140, d, r);
    chk("imr0_width", d, 32'h0000_FFFF);
    @(negedge clock);
    events[15] = 1'b1;
    @(negedge clock);
    events[15] = 1'b0;
    @(negedge clock);
    chk("irq0", 32'(irq), 32'b01);
    axi_rd(10'h160, d, r);
    chk("rd_isr0", d, 32'h0000_8000);

    @(negedge clock);
    araddr = 10'h160; arvalid = 1'b1; rready = 1'b0;
    @(negedge clock);
    arvalid = 1'b0;
    chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
    events = '1;
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    chk("mid_rst_ctrl", control, CRST);
    repeat (3) @(negedge clock);
    events = '0;
    rready = 1'b1;
    #2 resetn = 1'b1;
    axi_rd(10'h140, d, r);
    chk("post_imr0", d, 32'h0);
    axi_rd(10'h144, d, r);
    chk("post_imr1", d, 32'h0);
    axi_rd(10'h160, d, r);
    chk("post_isr0", d, 32'h0);
    axi_rd(10'h164, d, r);
    chk("post_isr1", d, 32'h0);
    axi_rd(10'h004, d, r);
    chk("post_ctrl", d, CRST);

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
